// File: rtl/mmio_bus_arbiter_if.sv
// mmio_bus_arbiter_if: requester-side and peripheral-side signals of the MMIO bus arbiter.
interface mmio_bus_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [1:0]  psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;

    modport master (
        input  req, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, prdata, pready,
        output done, err, rdata, paddr, pwrite, pwdata, psel, penable
    );

    modport slave (
        output req, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, prdata, pready,
        input  done, err, rdata, paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: round-robin two-port MMIO bus arbiter with address decode and setup/access sequencing.
// Optional ACCESS-phase timeout is enabled by defining MMIO_BUS_TIMEOUT_EN.
module mmio_bus_arbiter #(
    parameter logic [31:0] MMIO_LOW  = 32'hFFFF0000,
    parameter logic [31:0] MMIO_HIGH = 32'hFFFF0010,
    parameter logic [31:0] UART_ADDR = 32'hFFFF0000,
    parameter logic [31:0] ETH_ADDR  = 32'hFFFF0008
`ifdef MMIO_BUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input logic                clk,
    input logic                reset,
    mmio_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_winner;
    logic [1:0]  r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_paddr;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic [1:0]  r_psel;
    logic        r_penable;
`ifdef MMIO_BUS_TIMEOUT_EN
    logic [4:0]  r_cnt;
`endif

    logic [1:0]  w_elig;
    logic        w_pick;
    logic [31:0] w_addr;
    logic [1:0]  w_psel;

    // A port whose done pulse is out this cycle is not eligible, so it cannot be re-granted on stale req.
    always_comb begin
        w_elig = bus.req & ~r_done;
        w_pick = (&w_elig) ? ~r_last : w_elig[1];
        w_addr = w_pick ? bus.req_addr1 : bus.req_addr0;
        w_psel = (w_addr < MMIO_LOW || w_addr > MMIO_HIGH) ? 2'b01 :
                 (w_addr == UART_ADDR) ? 2'b10 :
                 (w_addr == ETH_ADDR)  ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk) begin
        r_done  <= 2'b00;
        r_err   <= 1'b0;
        r_rdata <= '0;
        if (reset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_winner  <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_psel    <= 2'b00;
            r_penable <= 1'b0;
`ifdef MMIO_BUS_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (|w_elig) begin
                    r_winner <= w_pick;
                    r_paddr  <= w_addr;
                    r_pwdata <= w_pick ? bus.req_wdata1 : bus.req_wdata0;
                    r_pwrite <= bus.req_write[w_pick];
                    r_psel   <= w_psel;
                    r_state  <= SETUP;
                end
                SETUP: if (r_psel == 2'b00) begin
                    r_done[r_winner] <= 1'b1;
                    r_err            <= 1'b1;
                    r_last           <= r_winner;
                    r_state          <= IDLE;
                end else begin
                    r_penable <= 1'b1;
`ifdef MMIO_BUS_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                    r_state   <= ACCESS;
                end
                ACCESS: if (bus.pready) begin
                    r_done[r_winner] <= 1'b1;
                    r_rdata          <= r_pwrite ? '0 : bus.prdata;
                    r_psel           <= 2'b00;
                    r_penable        <= 1'b0;
                    r_last           <= r_winner;
                    r_state          <= IDLE;
                end
`ifdef MMIO_BUS_TIMEOUT_EN
                else if (r_cnt == 5'(TIMEOUT_CYCLES - 1)) begin
                    r_done[r_winner] <= 1'b1;
                    r_err            <= 1'b1;
                    r_psel           <= 2'b00;
                    r_penable        <= 1'b0;
                    r_last           <= r_winner;
                    r_state          <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 5'd1;
                end
`endif
                default: begin
                    r_psel    <= 2'b00;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
    assign bus.paddr   = r_paddr;
    assign bus.pwrite  = r_pwrite;
    assign bus.pwdata  = r_pwdata;
    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb_mmio_bus_arbiter: directed self-checking bench for mmio_bus_arbiter (timeout case under MMIO_BUS_TIMEOUT_EN).
module tb_mmio_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mmio_bus_arbiter_if bus ();
    mmio_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int rem0, rem1, n, ovl;
        logic [5:0] ord;
        reset = 1'b1;
        bus.req = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;
        bus.req_wdata0 = '0;
        bus.req_wdata1 = '0;
        bus.prdata = '0;
        bus.pready = 1'b0;
        step(2);
        chk("reset_ctl", {bus.done, bus.err, bus.psel, bus.penable, bus.pwrite}, '0);
        chk("reset_data", {bus.paddr, bus.pwdata}, '0);
        chk("reset_rdata", bus.rdata, '0);

        // port 0 read from UART, pready on first ACCESS cycle
        reset = 1'b0;
        bus.req = 2'b01;
        bus.req_addr0 = 32'hFFFF0000;
        step();
        chk("t1_setup_ctl", {bus.psel, bus.penable, bus.done}, {2'b10, 1'b0, 2'b00});
        chk("t1_setup_addr", bus.paddr, 32'hFFFF0000);
        step();
        chk("t1_access_ctl", {bus.psel, bus.penable, bus.done}, {2'b10, 1'b1, 2'b00});
        bus.pready = 1'b1;
        bus.prdata = 32'hA5A5A5A5;
        step();
        chk("t1_done", {bus.done, bus.err, bus.psel, bus.penable}, {2'b01, 1'b0, 2'b00, 1'b0});
        chk("t1_rdata", bus.rdata, 32'hA5A5A5A5);
        bus.req = 2'b00;
        bus.pready = 1'b0;
        step();
        chk("t1_after", {bus.done, bus.err, bus.rdata}, '0);

        // port 1 write to memory with 4 wait cycles
        bus.req = 2'b10;
        bus.req_write = 2'b10;
        bus.req_addr1 = 32'h00001000;
        bus.req_wdata1 = 32'h12345678;
        bus.prdata = 32'hDEADBEEF;
        step();
        chk("t2_setup_ctl", {bus.psel, bus.pwrite, bus.penable}, {2'b01, 1'b1, 1'b0});
        chk("t2_setup_bus", {bus.paddr, bus.pwdata}, {32'h00001000, 32'h12345678});
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t2_wait_ctl", {bus.psel, bus.pwrite, bus.penable, bus.done}, {2'b01, 1'b1, 1'b1, 2'b00});
            chk("t2_wait_bus", {bus.paddr, bus.pwdata}, {32'h00001000, 32'h12345678});
            step();
        end
        bus.pready = 1'b1;
        step();
        chk("t2_done", {bus.done, bus.err, bus.penable, bus.psel}, {2'b10, 1'b0, 1'b0, 2'b00});
        chk("t2_rdata", bus.rdata, 32'h0);
        bus.req = 2'b00;
        bus.req_write = 2'b00;
        step();
        chk("t2_after", {bus.done, bus.err}, '0);

        // both ports, three back-to-back reads each, from reset
        reset = 1'b1;
        bus.req_addr0 = 32'h00000100;
        bus.req_addr1 = 32'h00000200;
        bus.pready = 1'b1;
        bus.req = 2'b11;
        step();
        reset = 1'b0;
        rem0 = 3;
        rem1 = 3;
        n = 0;
        ovl = 0;
        ord = '0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            step();
            if (&bus.done) ovl++;
            if (bus.done[0]) begin
                rem0--;
                if (n < 6) ord[n] = 1'b0;
                n++;
            end
            if (bus.done[1]) begin
                rem1--;
                if (n < 6) ord[n] = 1'b1;
                n++;
            end
            bus.req[0] = !bus.done[0] && rem0 > 0;
            bus.req[1] = !bus.done[1] && rem1 > 0;
        end
        chk("t3_count", n, 6);
        chk("t3_order", ord, 6'b101010);
        chk("t3_overlap", ovl, 0);
        bus.req = 2'b00;
        bus.pready = 1'b0;
        step(2);

        // port 0 unmapped read
        bus.req = 2'b01;
        bus.req_addr0 = 32'hFFFF0004;
        bus.prdata = 32'h55AA55AA;
        step();
        chk("t4_setup", {bus.psel, bus.penable, bus.done}, '0);
        step();
        chk("t4_done", {bus.done, bus.err, bus.penable, bus.psel}, {2'b01, 1'b1, 1'b0, 2'b00});
        chk("t4_rdata", bus.rdata, 32'h0);
        bus.req = 2'b00;
        step();
        chk("t4_after", {bus.done, bus.err}, '0);

        // reset during port 1 ACCESS, then port 0 must win the tie
        bus.req = 2'b10;
        bus.req_addr1 = 32'h00002000;
        step(2);
        chk("t5_access", {bus.psel, bus.penable}, {2'b01, 1'b1});
        reset = 1'b1;
        step();
        chk("t5_reset", {bus.psel, bus.penable, bus.done, bus.err}, '0);
        reset = 1'b0;
        bus.req = 2'b11;
        bus.req_addr0 = 32'h00003000;
        step();
        chk("t5_nodone", bus.done, 2'b00);
        chk("t5_grant0", bus.paddr, 32'h00003000);
        bus.pready = 1'b1;
        bus.prdata = 32'h0BADF00D;
        step(2);
        chk("t5_done0", {bus.done, bus.err, bus.rdata}, {2'b01, 1'b0, 32'h0BADF00D});
        bus.req = 2'b10;
        step();
        chk("t5_grant1", bus.paddr, 32'h00002000);
        step(2);
        chk("t5_done1", bus.done, 2'b10);
        bus.req = 2'b00;
        bus.pready = 1'b0;
        step();

`ifdef MMIO_BUS_TIMEOUT_EN
        // port 0 to ETH with pready held low: abort after 16 ACCESS cycles
        bus.req = 2'b01;
        bus.req_addr0 = 32'hFFFF0008;
        step();
        chk("t6_setup", {bus.psel, bus.penable}, {2'b11, 1'b0});
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t6_wait", {bus.psel, bus.penable, bus.done}, {2'b11, 1'b1, 2'b00});
        end
        step();
        chk("t6_done", {bus.done, bus.err, bus.psel, bus.penable, bus.rdata}, {2'b01, 1'b1, 2'b00, 1'b0, 32'h0});
        bus.req = 2'b00;
        step();
        chk("t6_idle", {bus.psel, bus.penable, bus.done, bus.err}, '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single MMIO/peripheral bus between two requesters: port 0 is the CPU load/store stage, port 1 is the DMA engine.
- Arbitrates round-robin and decodes the target peripheral from the address.
- Sequences each transfer through setup and access phases with a pready handshake, then returns a one-cycle done pulse and read data to the winning requester.

Parameters:
- MMIO_LOW, 32'hFFFF0000, lowest MMIO address (inclusive)
- MMIO_HIGH, 32'hFFFF0010, highest MMIO address (inclusive)
- UART_ADDR, 32'hFFFF0000, UART register address
- ETH_ADDR, 32'hFFFF0008, ethernet input register address
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  2  per-requester transfer request; held until that requester's done
- req_write  in  2  per-requester 1=write, 0=read
- req_addr0 / req_addr1  in  32 each  transfer address, word-aligned
- req_wdata0 / req_wdata1  in  32 each  write data
- done  out  2  one-cycle completion pulse, one bit per requester
- err  out  1  valid with done; 1 = unmapped address or timeout
- rdata  out  32  read data, valid while done is high
- paddr  out  32  bus address
- pwrite  out  1  bus direction
- pwdata  out  32  bus write data
- psel  out  2  00 = none, 01 = memory, 10 = uart, 11 = ethernet
- penable  out  1  access-phase strobe
- prdata  in  32  peripheral read data
- pready  in  1  peripheral completion

Behaviour:
- Reset values (all outputs registered):
  - state IDLE; last-grant pointer = 1, so port 0 wins the first tie.
  - done, err, rdata, paddr, pwdata, pwrite, psel, penable all 0.
- Decode, performed at grant:
  - addr outside [MMIO_LOW, MMIO_HIGH] -> psel 01.
  - addr == UART_ADDR -> 10.
  - addr == ETH_ADDR -> 11.
  - any other in-range addr -> 00 (unmapped).
- IDLE:
  - A requester is eligible if its req=1 and its done bit is 0 in this cycle. Requesters drop req the cycle done is seen.
  - One eligible: grant it.
  - Both eligible: grant the port that is not the last-grant pointer.
  - On grant: latch addr, wdata, write and decoded psel onto the bus regs; go to SETUP.
  - None eligible: stay in IDLE, psel = 00.
- SETUP (1 cycle):
  - psel, paddr, pwdata, pwrite driven; penable = 0.
  - If psel = 00: next cycle done[winner] = 1, err = 1, rdata = 0; go to IDLE; no ACCESS phase.
  - Otherwise: go to ACCESS with penable = 1.
- ACCESS:
  - Hold all bus signals, penable = 1.
  - pready = 0: stay in ACCESS indefinitely (without the optional feature).
  - pready = 1 sampled: next cycle done[winner] = 1, err = 0, rdata = prdata (for writes rdata = 0). Clear psel and penable, update last-grant to the winner, go to IDLE.
- Latency: req seen in IDLE at cycle T, SETUP at T+1, ACCESS at T+2. With pready = 1 at T+2, done at T+3. Minimum 3 cycles from grant to done; next grant no earlier than T+3.
- done is at most one-hot and lasts exactly one cycle. The rdata/err values are cleared the following cycle.
- req changes from the granted requester mid-transfer are ignored, since the transfer uses latched values. A req drop by the non-granted port has no effect.
- Reset mid-transfer: abort immediately to IDLE, no done pulse, pointer reset to 1.
- Unknown state encoding: recover to IDLE.

Optional Feature:
- Macro: MMIO_BUS_TIMEOUT_EN.
- Defined:
  - A 5-bit counter clears on ACCESS entry and increments each ACCESS cycle with pready = 0.
  - When it reaches TIMEOUT_CYCLES: next cycle done[winner] = 1, err = 1, rdata = 0; bus cleared; go to IDLE.
  - A pready = 1 in the same cycle as the limit wins: normal completion, err = 0.
- Undefined: no counter, and ACCESS waits for pready forever.

Test Plan:
- Port 0 read addr 0xFFFF0000, prdata 0xA5A5A5A5, pready high on the first ACCESS cycle -> psel = 10, penable 0 then 1, done = 01 at T+3, rdata = 0xA5A5A5A5, err = 0.
- Port 1 write addr 0x00001000 data 0x12345678, pready delayed 4 cycles -> psel = 01, pwrite = 1, pwdata = 0x12345678 held stable through 4 wait cycles, done = 10 one cycle after pready.
- Both req asserted from reset, each doing 3 back-to-back transfers -> grants alternate 0,1,0,1,0,1 with no starvation and no simultaneous done bits.
- Port 0 read addr 0xFFFF0004 (unmapped) -> no penable, done = 01 with err = 1, rdata = 0 at T+2.
- Reset asserted during ACCESS of a port 1 transfer -> next cycle state IDLE, psel = 0, penable = 0, no done; with both req high afterwards, port 0 is granted first.
- With MMIO_BUS_TIMEOUT_EN defined, port 0 targets ETH_ADDR with pready held 0 -> after 16 ACCESS cycles, done = 01 and err = 1; bus idle the next cycle.
